// File: rtl/rom_select_ctrl_if.sv
// rom_select_ctrl_if: front-panel buttons, main_mem handshake and status of the ROM selector
interface rom_select_ctrl_if #(
  parameter int NUM_BTN = 4,
  parameter int IDX_W   = 4
);
  logic [NUM_BTN-1:0] btn_n;
  logic               shift_n;
  logic               load_done;
  logic               reload;
  logic [IDX_W-1:0]   index;
  logic               busy;
  logic [NUM_BTN:0]   btn_db;
  modport master (output btn_n, shift_n, load_done, input reload, index, busy, btn_db);
  modport slave  (input btn_n, shift_n, load_done, output reload, index, busy, btn_db);
endinterface

// File: rtl/rom_select_ctrl.sv
// rom_select_ctrl: debounced ROM selector issuing one reload pulse per selection; ROM_SEL_NEXTPREV_EN adds NEXT/PREV buttons
module rom_select_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int IDX_W           = 4,
  parameter int NUM_ROMS        = 8,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LOAD_TIMEOUT    = 1 << 24
) (
  input logic clock,
  input logic reset,
  rom_select_ctrl_if.slave bus
);
  localparam int NIN = NUM_BTN + 1;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int TW  = $clog2(LOAD_TIMEOUT);
  localparam int CW  = IDX_W + 1;
`ifdef ROM_SEL_NEXTPREV_EN
  localparam int NSEL = NUM_BTN - 2;
`else
  localparam int NSEL = NUM_BTN;
`endif
  typedef enum logic [1:0] {IDLE, ARMED, FIRE, WAIT_LOAD} state_t;
  logic [NIN-1:0]     raw, db_q, db_d;
  logic [NUM_BTN-1:0] rise_q, rise_d;
  logic [DW-1:0]      cnt_q [NIN];
  logic [DW-1:0]      cnt_d [NIN];
  logic [CW-1:0]      low, cand;
  logic               cand_ok, sel_rise, held_any, nav_go;
  logic [IDX_W-1:0]   nav_idx, pending_q, pending_d, index_q, index_d;
  logic [TW-1:0]      to_q, to_d;
  logic               seen_low_q, seen_low_d, reload_q, reload_d, busy_q, busy_d;
  state_t             state_q, state_d;
  assign raw = {~bus.shift_n, ~bus.btn_n};
  // Debounce: a differing raw level must persist DEBOUNCE_CYCLES cycles before it is accepted
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      db_d[i]  = db_q[i];
      if (raw[i] != db_q[i]) begin
        db_d[i]  = (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? ~db_q[i] : db_q[i];
        cnt_d[i] = (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + 1'b1;
      end
    end
    rise_d = db_d[NUM_BTN-1:0] & ~db_q[NUM_BTN-1:0];
  end
  // Candidate index from the lowest held select plus the shift bank offset, and NEXT/PREV wrap targets
  always_comb begin
    low = '0;
    for (int i = NSEL - 1; i >= 0; i--) if (db_q[i]) low = CW'(i);
    cand     = low + (db_q[NUM_BTN] ? CW'(NSEL) : '0);
    cand_ok  = (|db_q[NSEL-1:0]) && (cand < CW'(NUM_ROMS));
    sel_rise = |rise_q[NSEL-1:0];
    held_any = |db_q[NUM_BTN-1:0];
`ifdef ROM_SEL_NEXTPREV_EN
    nav_go  = rise_q[NUM_BTN-1] | rise_q[NUM_BTN-2];
    nav_idx = rise_q[NUM_BTN-1] ? ((index_q == IDX_W'(NUM_ROMS - 1)) ? '0 : index_q + 1'b1)
                                : ((index_q == '0) ? IDX_W'(NUM_ROMS - 1) : index_q - 1'b1);
`else
    nav_go  = 1'b0;
    nav_idx = '0;
`endif
  end
  // Selection FSM: arm on a fresh press, fire on release, then wait out the main_mem load
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    to_d       = to_q;
    seen_low_d = seen_low_q;
    case (state_q)
      IDLE: begin
        state_d   = (nav_go || (sel_rise && cand_ok)) ? ARMED : IDLE;
        pending_d = nav_go ? nav_idx : (sel_rise && cand_ok) ? cand[IDX_W-1:0] : pending_q;
      end
      ARMED: begin
        state_d   = held_any ? ARMED : FIRE;
        pending_d = (held_any && cand_ok) ? cand[IDX_W-1:0] : pending_q;
      end
      FIRE: begin
        state_d    = WAIT_LOAD;
        to_d       = '0;
        seen_low_d = 1'b0;
      end
      default: begin
        to_d       = to_q + 1'b1;
        seen_low_d = seen_low_q | ~bus.load_done;
        state_d    = ((seen_low_q && bus.load_done) || to_q == TW'(LOAD_TIMEOUT - 1)) ? IDLE : WAIT_LOAD;
      end
    endcase
    index_d  = (state_d == FIRE) ? pending_q : index_q;
    reload_d = state_d == FIRE;
    busy_d   = (state_d == FIRE) || (state_d == WAIT_LOAD);
  end
  // State and registered outputs, all cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      db_q       <= '0;
      rise_q     <= '0;
      state_q    <= IDLE;
      pending_q  <= '0;
      index_q    <= '0;
      to_q       <= '0;
      seen_low_q <= 1'b0;
      reload_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
      db_q       <= db_d;
      rise_q     <= rise_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
      index_q    <= index_d;
      to_q       <= to_d;
      seen_low_q <= seen_low_d;
      reload_q   <= reload_d;
      busy_q     <= busy_d;
    end
  end
  assign bus.reload = reload_q;
  assign bus.index  = index_q;
  assign bus.busy   = busy_q;
  assign bus.btn_db = db_q;
endmodule

// File: tb/tb_rom_select_ctrl.sv
// tb_rom_select_ctrl: directed and random selections on two selectors (8 and 6 ROM slots) against a slot-arithmetic model
module tb_rom_select_ctrl;
  logic clk = 1'b0;
  logic rst;
  int total = 0, passed = 0, fails = 0;
  int rl8 = 0, rl6 = 0, m8 = 0, m6 = 0;
  logic prev8 = 1'b0, prev6 = 1'b0;
  rom_select_ctrl_if #(.NUM_BTN(4), .IDX_W(4)) ia ();
  rom_select_ctrl_if #(.NUM_BTN(4), .IDX_W(4)) ib ();
  assign ib.btn_n     = ia.btn_n;
  assign ib.shift_n   = ia.shift_n;
  assign ib.load_done = ia.load_done;
  rom_select_ctrl #(.NUM_BTN(4), .IDX_W(4), .NUM_ROMS(8), .DEBOUNCE_CYCLES(4), .LOAD_TIMEOUT(16))
    d8 (.clock(clk), .reset(rst), .bus(ia));
  rom_select_ctrl #(.NUM_BTN(4), .IDX_W(4), .NUM_ROMS(6), .DEBOUNCE_CYCLES(4), .LOAD_TIMEOUT(16))
    d6 (.clock(clk), .reset(rst), .bus(ib));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Expected new slot after a press of mask m (with shift sh) from current slot cur; -1 means rejected
  function automatic int model(input logic sh, input logic [3:0] m, input int cur, input int nr);
    int ns = 4;
    int c = -1;
`ifdef ROM_SEL_NEXTPREV_EN
    if (m[3]) return (cur + 1) % nr;
    if (m[2]) return (cur + nr - 1) % nr;
    ns = 2;
`endif
    for (int b = ns - 1; b >= 0; b--) if (m[b]) c = b;
    if (c < 0) return -1;
    c += sh ? ns : 0;
    return c < nr ? c : -1;
  endfunction
  // Count reload pulses and require every pulse to be a single cycle
  always @(posedge clk) begin
    #1;
    if (ia.reload) begin chk("reload8_single", 32'(prev8), 0); rl8++; end
    if (ib.reload) begin chk("reload6_single", 32'(prev6), 0); rl6++; end
    prev8 = ia.reload;
    prev6 = ib.reload;
  end
  // mode 0 normal load, 1 press during load, 2 load_done never drops, 3 reset during load
  task automatic finish(input int e8, input int e6, input int mode, input int d1, input int d2);
    int r8, r6;
    bit got;
    r8 = rl8;
    r6 = rl6;
    ia.btn_n = '1;
    ia.shift_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin step(1); got = ia.reload; end
    if (got && mode == 2) begin
      step(16); chk("timeout_busy_hold", ia.busy, 1);
      step(1);  chk("timeout_idle", ia.busy, 0);
    end else if (got && mode == 3) begin
      step(3); rst = 1'b1;
      step(1);
      chk("rst_busy", ia.busy, 0);
      chk("rst_index", ia.index, 0);
      chk("rst_reload", ia.reload, 0);
      chk("rst_btn_db", ia.btn_db, 0);
      rst = 1'b0;
    end else if (got) begin
      if (mode == 1) ia.btn_n = 4'b1011;
      step(d1); ia.load_done = 1'b0; ia.btn_n = '1;
      step(d2); chk("busy_in_load", ia.busy, 1);
      ia.load_done = 1'b1;
      step(1); chk("busy_after_done", ia.busy, 0);
    end
    step(12);
    if (e8 >= 0) m8 = e8;
    if (e6 >= 0) m6 = e6;
    if (mode == 3) begin m8 = 0; m6 = 0; end
    chk("reload8_count", rl8 - r8, e8 >= 0);
    chk("reload6_count", rl6 - r6, e6 >= 0);
    chk("index8", ia.index, m8);
    chk("index6", ib.index, m6);
  endtask
  task automatic txn(input logic sh, input logic [3:0] m, input int mode, input int d1, input int d2);
    int e8, e6;
    e8 = model(sh, m, m8, 8);
    e6 = model(sh, m, m6, 6);
    ia.shift_n = ~sh;
    ia.btn_n = ~m;
    step(8);
    finish(e8, e6, mode, d1, d2);
  endtask
  initial begin
    logic sh;
    logic [3:0] m;
    rst = 1'b1;
    ia.btn_n = '1;
    ia.shift_n = 1'b1;
    ia.load_done = 1'b1;
    step(2);
    chk("reset_reload", ia.reload, 0);
    chk("reset_index", ia.index, 0);
    chk("reset_busy", ia.busy, 0);
    chk("reset_btn_db", ia.btn_db, 0);
    rst = 1'b0;
    step(1);
`ifndef ROM_SEL_NEXTPREV_EN
    ia.btn_n = 4'b1101;
    step(3);
    ia.btn_n = '1;
    for (int i = 0; i < 6; i++) begin step(1); chk("glitch_db", ia.btn_db, 0); end
    chk("glitch_reload", rl8, 0);
    ia.btn_n = 4'b1101;
    step(3); chk("db_latency_3", ia.btn_db, 0);
    step(1); chk("db_latency_4", ia.btn_db, 5'b00010);
    step(4);
    finish(model(0, 4'b0010, m8, 8), model(0, 4'b0010, m6, 6), 0, 3, 5);
    txn(0, 4'b0100, 0, 5, 9);
    txn(1, 4'b0010, 0, 2, 3);
    txn(1, 4'b1000, 0, 3, 4);
    ia.btn_n = 4'b1110; step(6);
    ia.btn_n = 4'b0110; step(6);
    ia.btn_n = 4'b0111; step(6);
    finish(3, 3, 1, 6, 3);
    txn(0, 4'b0001, 2, 0, 0);
    txn(0, 4'b0010, 3, 0, 0);
`else
    txn(0, 4'b0100, 0, 2, 3);
    txn(0, 4'b1000, 0, 2, 3);
    txn(1, 4'b0010, 0, 2, 3);
    txn(0, 4'b1100, 0, 2, 3);
`endif
    for (int k = 0; k < 10; k++) begin
      sh = 1'($urandom_range(0, 1));
      m = 4'($urandom_range(1, 15));
`ifdef ROM_SEL_NEXTPREV_EN
      if (m[3:2] != 2'b00) m[1:0] = 2'b00;
`endif
      txn(sh, m, 0, $urandom_range(1, 5), $urandom_range(1, 8));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
